// File: rtl/ifsram_pkg.sv
// Shared definitions for the input-feature SRAM reader/writer blocks:
// FSM encodings, default geometry and a small width helper.
package ifsram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_DONE  = 2'd2
  } wr_state_t;

  localparam int IFS_TBITS  = 64;
  localparam int IFS_TBYTE  = 8;
  localparam int IFS_ROW    = 3;
  localparam int IFS_COL    = 15;
  localparam int IFS_CH     = 4;
  localparam int IFS_ADDR_W = 11;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int min_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ifsram_addr_gen.sv
// Address generator for the feature-row ring buffer: ch innermost, then col,
// then row, with the slot wrapping ROW-1 -> 0. Column COL is only visited
// when PAD_EN is set (zero-padding column).
module ifsram_addr_gen
  import ifsram_pkg::*;
#(
  parameter int ROW    = IFS_ROW,
  parameter int COL    = IFS_COL,
  parameter int CH     = IFS_CH,
  parameter bit PAD_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [1:0]            load_slot,
  input  logic [1:0]            load_rows,
  input  logic                  step,
  output logic [IFS_ADDR_W-1:0] addr,
  output logic                  in_pad,
  output logic                  last_word,
  output logic [1:0]            slot_wrap
);

  localparam int CH_W      = min_width(CH);
  localparam int COL_W     = min_width(COL + 1);
  localparam int LAST_COL  = PAD_EN ? COL : COL - 1;
  localparam int ROW_WORDS = (COL + 1) * CH;

  logic [CH_W-1:0]  ch_reg;
  logic [COL_W-1:0] col_reg;
  logic [1:0]       slot_reg;
  logic [1:0]       rows_left_reg;

  logic ch_last, col_last, row_last;

  assign ch_last   = (int'(ch_reg) == CH - 1);
  assign col_last  = (int'(col_reg) == LAST_COL);
  assign row_last  = (rows_left_reg == 2'd0);
  assign slot_wrap = (int'(slot_reg) == ROW - 1) ? 2'd0 : slot_reg + 2'd1;
  assign in_pad    = PAD_EN && (int'(col_reg) == COL);
  assign last_word = ch_last && col_last && row_last;
  assign addr      = IFS_ADDR_W'(int'(slot_reg) * ROW_WORDS + int'(col_reg) * CH + int'(ch_reg));

  // Counters load on an accepted command and advance one word per step.
  always_ff @(posedge clk) begin
    if (reset) begin
      ch_reg        <= '0;
      col_reg       <= '0;
      slot_reg      <= '0;
      rows_left_reg <= '0;
    end else if (load) begin
      ch_reg        <= '0;
      col_reg       <= '0;
      slot_reg      <= load_slot;
      rows_left_reg <= load_rows - 2'd1;
    end else if (step) begin
      if (ch_last) begin
        ch_reg <= '0;
        if (col_last) begin
          col_reg       <= '0;
          slot_reg      <= slot_wrap;
          rows_left_reg <= rows_left_reg - 2'd1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end else begin
        ch_reg <= ch_reg + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ifsram_w.sv
// Input-feature SRAM writer: streams DRAM words into the ifsram ring buffer
// one feature row at a time. Build option IFSRAM_W_PAD_ZERO_EN appends CH
// zero words (column COL) after each row without consuming input.
module ifsram_w
  import ifsram_pkg::*;
#(
  parameter int TBITS = IFS_TBITS,
  parameter int TBYTE = IFS_TBYTE,
  parameter int ROW   = IFS_ROW,
  parameter int COL   = IFS_COL,
  parameter int CH    = IFS_CH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  if_write_start,
  input  logic [1:0]            wr_rows,
  output logic                  if_write_busy,
  output logic                  if_write_done,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [TBITS-1:0]      din,
  output logic                  cen_writes_ifsram,
  output logic                  wen_writes_ifsram,
  output logic [IFS_ADDR_W-1:0] addr_write_ifsram,
  output logic [TBITS-1:0]      data_write_ifsram,
  output logic [1:0]            row_slot
);

`ifdef IFSRAM_W_PAD_ZERO_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam int LANE = TBITS / TBYTE;

  wr_state_t state_reg, state_next;
  logic [1:0] row_slot_reg;
  logic [1:0] rows_eff;
  logic       active, load, write_fire, pad_fire, step;
  logic       in_pad, last_word;
  logic [1:0] slot_wrap;
  logic [IFS_ADDR_W-1:0] addr_cur;

  // Reset also masks outputs combinationally so an abort never writes.
  assign active     = (state_reg == ST_WRITE) && !reset;
  assign load       = (state_reg == ST_IDLE) && if_write_start && !reset;
  assign rows_eff   = (wr_rows == 2'd0) ? 2'd1 : wr_rows;
  assign write_fire = active && !in_pad && din_valid;
  assign pad_fire   = active && in_pad;
  assign step       = write_fire || pad_fire;

  ifsram_addr_gen #(
    .ROW    (ROW),
    .COL    (COL),
    .CH     (CH),
    .PAD_EN (PAD_EN)
  ) u_addr_gen (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_slot (row_slot_reg),
    .load_rows (rows_eff),
    .step      (step),
    .addr      (addr_cur),
    .in_pad    (in_pad),
    .last_word (last_word),
    .slot_wrap (slot_wrap)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and status outputs.
  always_comb begin
    state_next    = state_reg;
    if_write_busy = 1'b0;
    if_write_done = 1'b0;
    case (state_reg)
      ST_IDLE:  if (if_write_start) state_next = ST_WRITE;
      ST_WRITE: begin
        if_write_busy = !reset;
        if (step && last_word) state_next = ST_DONE;
      end
      ST_DONE: begin
        if_write_done = !reset;
        state_next    = ST_IDLE;
      end
      default:  state_next = ST_IDLE;
    endcase
  end

  // The slot after the final row becomes the first slot of the next command.
  always_ff @(posedge clk) begin
    if (reset)                  row_slot_reg <= 2'd0;
    else if (step && last_word) row_slot_reg <= slot_wrap;
  end

  assign row_slot          = row_slot_reg;
  assign din_ready         = active && !in_pad;
  assign cen_writes_ifsram = !step;
  assign wen_writes_ifsram = !step;
  assign addr_write_ifsram = step ? addr_cur : '0;

  // Data lanes: input word on a real write, zero on pad or idle cycles.
  for (genvar gi = 0; gi < TBYTE; gi++) begin : g_lane
    assign data_write_ifsram[gi*LANE +: LANE] = write_fire ? din[gi*LANE +: LANE] : '0;
  end

endmodule
